// File: rtl/exibe_sequencia_if.sv
// Signal bundle between the sequence presenter, the game controller,
// the sequence ROM and the LED/debug outputs.
interface exibe_sequencia_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic [DATA_W-1:0] mem_dado;
    logic [ADDR_W-1:0] mem_endereco;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              pronto;
    logic [3:0]        db_estado;

    // Controller/ROM side: issues the start request and returns ROM data.
    modport master (
        output iniciar, limite, mem_dado,
        input  mem_endereco, leds, ocupado, pronto, db_estado
    );

    // Presenter side.
    modport slave (
        input  iniciar, limite, mem_dado,
        output mem_endereco, leds, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/exibe_sequencia.sv
// Sequence presenter for the MindFocus memory game: walks the sync ROM from
// address 0 up to the captured limit and lights each entry on the player LEDs
// for T_ON cycles, followed by a T_OFF-cycle dark gap. Moore FSM with all
// outputs registered; pronto pulses once when the last gap completes.
module exibe_sequencia #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500
) (
    input logic               clock,
    input logic               reset,
    exibe_sequencia_if.slave  bus
);

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0] T_ON_M1  = TW'(T_ON - 1);
    localparam logic [TW-1:0] T_OFF_M1 = TW'(T_OFF - 1);

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        CARREGA = 4'h1,
        LE      = 4'h2,
        ACENDE  = 4'h3,
        APAGA   = 4'h4,
        PROXIMO = 4'h5,
        FIM     = 4'hF
    } estado_t;

    estado_t           estado;
    logic [ADDR_W-1:0] endereco;
    logic [ADDR_W-1:0] limite_r;
    logic [DATA_W-1:0] leds_r;
    logic [TW-1:0]     timer;
    logic              ocupado_r;
    logic              pronto_r;

    // Controller FSM: address counter, interval timer and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            endereco  <= '0;
            limite_r  <= '0;
            leds_r    <= '0;
            timer     <= '0;
            ocupado_r <= 1'b0;
            pronto_r  <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            case (estado)
                INICIAL: begin
                    if (bus.iniciar) begin
                        endereco  <= '0;
                        limite_r  <= bus.limite;
                        ocupado_r <= 1'b1;
                        estado    <= CARREGA;
                    end
                end
                // The ROM samples the stable address on this edge.
                CARREGA: begin
                    estado <= LE;
                end
                LE: begin
                    leds_r <= bus.mem_dado;
                    timer  <= '0;
                    estado <= ACENDE;
                end
                ACENDE: begin
                    if (timer == T_ON_M1) begin
                        leds_r <= '0;
                        timer  <= '0;
                        estado <= APAGA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                APAGA: begin
                    if (timer == T_OFF_M1) begin
                        timer  <= '0;
                        estado <= PROXIMO;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                // Compare before incrementing so the address never wraps.
                PROXIMO: begin
                    if (endereco == limite_r) begin
                        pronto_r <= 1'b1;
                        estado   <= FIM;
                    end else begin
                        endereco <= endereco + ADDR_W'(1);
                        estado   <= CARREGA;
                    end
                end
                FIM: begin
                    ocupado_r <= 1'b0;
                    estado    <= INICIAL;
                end
                default: begin
                    leds_r    <= '0;
                    timer     <= '0;
                    ocupado_r <= 1'b0;
                    estado    <= INICIAL;
                end
            endcase
        end
    end

    assign bus.mem_endereco = endereco;
    assign bus.leds         = leds_r;
    assign bus.ocupado      = ocupado_r;
    assign bus.pronto       = pronto_r;
    assign bus.db_estado    = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with T_ON=3, T_OFF=2 (8 cycles per entry).
// A behavioural sync ROM answers one cycle after the address is sampled.
module tb_exibe_sequencia;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int T_ON   = 3;
    localparam int T_OFF  = 2;
    localparam int PER    = T_ON + T_OFF + 3;

    logic clock;
    logic reset;
    logic [DATA_W-1:0] rom [16];

    int n_tests;
    int n_fail;

    exibe_sequencia_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    exibe_sequencia #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .T_ON  (T_ON),
        .T_OFF (T_OFF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM model.
    always @(posedge clock) bus.mem_dado <= rom[bus.mem_endereco];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int addr);
        check_eq({tag, "_leds"}, 32'(bus.leds), 32'd0);
        check_eq({tag, "_ocup"}, 32'(bus.ocupado), 32'd0);
        check_eq({tag, "_pronto"}, 32'(bus.pronto), 32'd0);
        check_eq({tag, "_est"}, 32'(bus.db_estado), 32'd0);
        check_eq({tag, "_addr"}, 32'(bus.mem_endereco), 32'(addr));
    endtask

    // Starts a playback of entries 0..lim and checks every output each cycle
    // through the FIM pulse and the following idle cycle. Returns at the
    // falling edge of that idle cycle. pulse_at re-raises iniciar for the
    // edge of that index; hold keeps iniciar high throughout.
    task automatic play(input int lim, input int pulse_at, input bit hold);
        int fim_n;
        int k;
        int p;
        int e_leds;
        int e_addr;
        int e_est;
        int e_ocup;
        int e_pr;
        string tag;
        fim_n = PER * (lim + 1);
        bus.limite  = ADDR_W'(lim);
        bus.iniciar = 1'b1;
        @(posedge clock);
        for (int n = 0; n <= fim_n + 1; n++) begin
            @(negedge clock);
            bus.iniciar = hold || (pulse_at == n + 1);
            bus.limite  = ADDR_W'(lim ^ 5);
            k = n / PER;
            p = n % PER;
            if (n < fim_n) begin
                e_leds = (p >= 2 && p <= 4) ? int'(rom[k]) : 0;
                e_addr = k;
                e_est  = (p == 0) ? 1 : (p == 1) ? 2 : (p <= 4) ? 3 : (p <= 6) ? 4 : 5;
                e_ocup = 1;
                e_pr   = 0;
            end else if (n == fim_n) begin
                e_leds = 0; e_addr = lim; e_est = 15; e_ocup = 1; e_pr = 1;
            end else begin
                e_leds = 0; e_addr = lim; e_est = 0; e_ocup = 0; e_pr = 0;
            end
            tag = $sformatf("lim%0d_c%0d", lim, n);
            check_eq({tag, "_leds"}, 32'(bus.leds), 32'(e_leds));
            check_eq({tag, "_addr"}, 32'(bus.mem_endereco), 32'(e_addr));
            check_eq({tag, "_est"}, 32'(bus.db_estado), 32'(e_est));
            check_eq({tag, "_ocup"}, 32'(bus.ocupado), 32'(e_ocup));
            check_eq({tag, "_pronto"}, 32'(bus.pronto), 32'(e_pr));
        end
    endtask

    initial begin
        int pulses;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 16; i++) rom[i] = DATA_W'(1 << (i % 4));
        rom[5] = '0;
        reset       = 1'b0;
        bus.iniciar = 1'b0;
        bus.limite  = '0;

        // Reset state, then 20 idle cycles with iniciar low.
        repeat (3) @(negedge clock);
        check_idle("rst", 0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_idle($sformatf("idle%0d", i), 0);
        end

        // Single entry.
        play(0, -1, 1'b0);
        // Four entries 1,2,4,8.
        play(3, -1, 1'b0);
        // Extra pulse while busy is ignored; held iniciar restarts after
        // exactly one idle cycle, verified by the following playback.
        play(1, 5, 1'b1);
        play(1, -1, 1'b0);

        // Asynchronous reset during ACENDE of entry 2.
        bus.limite  = 4'd3;
        bus.iniciar = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.iniciar = 1'b0;
        repeat (19) @(negedge clock);
        check_eq("pre_rst_leds", 32'(bus.leds), 32'd4);
        check_eq("pre_rst_addr", 32'(bus.mem_endereco), 32'd2);
        #2 reset = 1'b0;
        #1;
        check_idle("async_rst", 0);
        @(negedge clock);
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.pronto === 1'b1) pulses++;
        end
        check_eq("no_pronto_after_abort", 32'(pulses), 32'd0);
        check_idle("post_rst", 0);
        play(0, -1, 1'b0);

        // Full ROM, including a zero word at address 5.
        play(15, -1, 1'b0);
        repeat (5) @(negedge clock);
        check_idle("after_full", 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
